conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/conv_enc_step.sv | 22 ++
 rtl/conv_encoder.sv | 153 +++++++++++++++
 tb/tb_conv_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional encoder and
// its Viterbi decoder: word size, generator taps and FSM encoding.
package viterbi_pkg;

   localparam int VIT_DATA_W = 32;
   localparam int VIT_K      = 3;

   // Tap order for both generators is {u, s1, s2}, MSB first.
   localparam logic [VIT_K-1:0] VIT_G0 = 3'b111;
   localparam logic [VIT_K-1:0] VIT_G1 = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_DONE   = 2'd2
   } enc_state_t;

   // XOR of the register bits selected by a generator polynomial.
   function automatic logic tap_parity(
      input logic [VIT_K-1:0] g,
      input logic [VIT_K-1:0] r
   );
      return ^(g & r);
   endfunction

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the convolutional code: maps the current input
// bit and the two-bit state to the pair of code bits.
module conv_enc_step
   import viterbi_pkg::*;
#(
   parameter logic [VIT_K-1:0] G0 = VIT_G0,
   parameter logic [VIT_K-1:0] G1 = VIT_G1
) (
   input  logic u,
   input  logic s1,
   input  logic s2,
   output logic c0,
   output logic c1
);

   // Pure parity of the selected taps; shared with the decoder.
   always_comb begin
      c0 = tap_parity(G0, {u, s1, s2});
      c1 = tap_parity(G1, {u, s1, s2});
   end

endmodule

// File: rtl/conv_encoder.sv
// Word-at-a-time rate-1/2 convolutional encoder: captures a word,
// encodes it LSB first one bit per cycle, then holds the result.
module conv_encoder
   import viterbi_pkg::*;
#(
   parameter int               DATA_W = VIT_DATA_W,
   parameter logic [VIT_K-1:0] G0     = VIT_G0,
   parameter logic [VIT_K-1:0] G1     = VIT_G1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   in_stream,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [2*DATA_W-1:0] out_stream,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   enc_state_t state_q, state_d;

   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [2*DATA_W-1:0] out_q, out_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                s1_q, s1_d;
   logic                s2_q, s2_d;

   logic accept;
   logic step;
   logic last_bit;
   logic u;
   logic c0;
   logic c1;

   assign accept   = (state_q == ST_IDLE) && in_valid;
   assign step     = (state_q == ST_ENCODE);
   assign last_bit = (cnt_q == CNT_LAST);
   assign u        = sh_q[0];

   conv_enc_step #(
      .G0 (G0),
      .G1 (G1)
   ) u_step (
      .u  (u),
      .s1 (s1_q),
      .s2 (s2_q),
      .c0 (c0),
      .c1 (c1)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one word in flight at a time.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_ENCODE;
            end
         end
         ST_ENCODE: begin
            if (last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: handshakes are purely state-decoded, never both high.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE:   in_ready  = 1'b1;
         ST_DONE:   out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: capture on accept, shift one bit per ENCODE cycle, and
   // publish the finished codeword only on the terminal bit so the
   // visible output stays put until the next word completes.
   always_comb begin
      sh_d  = sh_q;
      acc_d = acc_q;
      out_d = out_q;
      cnt_d = cnt_q;
      s1_d  = s1_q;
      s2_d  = s2_q;
      if (accept) begin
         sh_d  = in_stream;
         acc_d = '0;
         cnt_d = '0;
         s1_d  = 1'b0;
         s2_d  = 1'b0;
      end else if (step) begin
         sh_d  = sh_q >> 1;
         acc_d = {c1, c0, acc_q[2*DATA_W-1:2]};
         s1_d  = u;
         s2_d  = s1_q;
         if (last_bit) begin
            out_d = acc_d;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         acc_q <= '0;
         out_q <= '0;
         cnt_q <= '0;
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         acc_q <= acc_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
      end
   end

   assign out_stream = out_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and random checks of conv_encoder against a bit-level
// encoder model and a hard-decision Viterbi round trip.
module tb_conv_encoder;
   import viterbi_pkg::*;

   localparam int W  = VIT_DATA_W;
   localparam int CW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  in_stream = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] out_stream;
   logic          out_valid;
   logic          out_ready = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   logic [CW-1:0] exp_q[$];
   logic [W-1:0]  word_q[$];

   always #5 clk = ~clk;

   conv_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_stream  (in_stream),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_stream (out_stream),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   function automatic logic [CW-1:0] ref_enc(input logic [W-1:0] w);
      logic [CW-1:0] r;
      logic s1, s2, b;
      r  = '0;
      s1 = 1'b0;
      s2 = 1'b0;
      for (int i = 0; i < W; i++) begin
         b          = w[i];
         r[2*i]     = b ^ s1 ^ s2;
         r[2*i+1]   = b ^ s2;
         s2         = s1;
         s1         = b;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] vit_dec(input logic [CW-1:0] cw);
      int pm[4];
      int npm[4];
      int surv[W][4];
      int best, m, ps, st;
      logic b, a1, a2, e0, e1;
      logic [W-1:0] d;
      logic [1:0] nsv;
      pm[0] = 0;
      pm[1] = 1000;
      pm[2] = 1000;
      pm[3] = 1000;
      for (int i = 0; i < W; i++) begin
         for (int ns = 0; ns < 4; ns++) begin
            nsv  = ns[1:0];
            b    = nsv[1];
            a1   = nsv[0];
            best = 1 << 20;
            for (int k = 0; k < 2; k++) begin
               a2 = (k != 0);
               ps = (a1 ? 2 : 0) + k;
               e0 = b ^ a1 ^ a2;
               e1 = b ^ a2;
               m  = pm[ps] + int'(e0 != cw[2*i]) + int'(e1 != cw[2*i+1]);
               if (m < best) begin
                  best        = m;
                  surv[i][ns] = ps;
               end
            end
            npm[ns] = best;
         end
         pm = npm;
      end
      st = 0;
      for (int ns = 1; ns < 4; ns++) begin
         if (pm[ns] < pm[st]) st = ns;
      end
      d = '0;
      for (int i = W - 1; i >= 0; i--) begin
         d[i] = (st >= 2);
         st   = surv[i][st];
      end
      return d;
   endfunction

   task automatic check(input string tag, input logic [CW-1:0] obs,
                        input logic [CW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [CW-1:0] e;
      logic [W-1:0]  w;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         w = word_q.pop_front();
         check(tag, out_stream, e);
         check({tag, "_viterbi"}, CW'(vit_dec(out_stream)), CW'(w));
      end
   endtask

   task automatic send(input logic [W-1:0] w);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("send_ready_timeout", CW'(in_ready), 1);
      in_valid  = 1'b1;
      in_stream = w;
      @(posedge clk);
      exp_q.push_back(ref_enc(w));
      word_q.push_back(w);
      @(negedge clk);
      in_valid  = 1'b0;
      in_stream = $urandom;
   endtask

   task automatic recv(input string tag, input int hold);
      int n;
      logic [CW-1:0] held;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid_timeout"}, CW'(out_valid), 1);
      held = out_stream;
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         check({tag, "_hold_stable"}, out_stream, held);
         check({tag, "_hold_in_ready"}, CW'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      pop_check(tag);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_after_valid"}, CW'(out_valid), 0);
      check({tag, "_after_in_ready"}, CW'(in_ready), 1);
      check({tag, "_retained"}, out_stream, held);
   endtask

   initial begin
      int edges, cyc, sent, got;
      logic prev_hold;
      logic [CW-1:0] prev_out;

      repeat (3) @(negedge clk);
      check("rst_out_stream", out_stream, 0);
      check("rst_out_valid", CW'(out_valid), 0);
      check("rst_in_ready", CW'(in_ready), 1);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", CW'(in_ready), 1);

      // Impulse with latency count and ignored in_valid while busy.
      send(32'h0000_0001);
      edges = 1;
      in_valid  = 1'b1;
      in_stream = 32'hDEAD_BEEF;
      while (!out_valid && edges < 100) begin
         @(negedge clk);
         edges++;
         if (!out_valid) begin
            check("busy_in_ready", CW'(in_ready), 0);
         end
      end
      in_valid = 1'b0;
      check("impulse_latency", CW'(edges), 33);
      check("impulse_value", out_stream, 64'h0000_0000_0000_0037);
      recv("impulse", 0);

      send(32'hFFFF_FFFF);
      recv("all_ones", 0);
      check("all_ones_value", out_stream, 64'h5555_5555_5555_555B);

      send(32'h1234_5678);
      recv("backpressure", 5);

      // Reset in the middle of a word.
      send(32'hA5A5_A5A5);
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_out_stream", out_stream, 0);
      check("mid_rst_out_valid", CW'(out_valid), 0);
      check("mid_rst_in_ready", CW'(in_ready), 1);
      exp_q.delete();
      word_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_mid_rst_valid", CW'(out_valid), 0);
      send(32'h0000_0001);
      recv("resend", 0);
      check("resend_value", out_stream, 64'h0000_0000_0000_0037);

      // Random traffic with random backpressure.
      cyc       = 0;
      sent      = 0;
      got       = 0;
      prev_hold = 1'b0;
      prev_out  = '0;
      while (got < 200 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (in_ready && out_valid) begin
            check("rand_both_high", 1, 0);
         end
         if (prev_hold) begin
            check("rand_hold_stable", out_stream, prev_out);
         end
         in_stream = $urandom;
         in_valid  = (sent < 200) && ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_enc(in_stream));
            word_q.push_back(in_stream);
            sent++;
         end
         if (out_valid && out_ready) begin
            pop_check("rand_word");
            got++;
         end
         prev_hold = out_valid && !out_ready;
         prev_out  = out_stream;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rand_word_count", CW'(got), 200);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
